// File: rtl/stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer_pkg
// Description : Shared FSM state type and width helpers for stream_packer.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int C_DEF_BIT_WIDTH = 8;
    localparam int C_DEF_NUM_WORDS = 4;

    // The instantiating module derives its lane-index and count widths from these.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic int cnt_width(input int num_words);
        return idx_width(num_words) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer_if
// Description : Narrow-in / wide-out val/rdy bundle for stream_packer.
//               Adds flush/ostream_cnt when STREAM_PACKER_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_packer_if
    import stream_packer_pkg::*;
#(
    parameter int P_BIT_WIDTH = C_DEF_BIT_WIDTH,
    parameter int P_NUM_WORDS = C_DEF_NUM_WORDS
);

    logic [P_BIT_WIDTH-1:0]             istream_msg;
    logic                               istream_val;
    logic                               istream_rdy;
    logic [P_BIT_WIDTH*P_NUM_WORDS-1:0] ostream_msg;
    logic                               ostream_val;
    logic                               ostream_rdy;

`ifdef STREAM_PACKER_FLUSH_EN
    localparam int C_CNT_W = cnt_width(P_NUM_WORDS);

    logic               flush;
    logic [C_CNT_W-1:0] ostream_cnt;

    modport master (
        output istream_msg, istream_val, ostream_rdy, flush,
        input  istream_rdy, ostream_msg, ostream_val, ostream_cnt
    );

    modport slave (
        input  istream_msg, istream_val, ostream_rdy, flush,
        output istream_rdy, ostream_msg, ostream_val, ostream_cnt
    );
`else
    modport master (
        output istream_msg, istream_val, ostream_rdy,
        input  istream_rdy, ostream_msg, ostream_val
    );

    modport slave (
        input  istream_msg, istream_val, ostream_rdy,
        output istream_rdy, ostream_msg, ostream_val
    );
`endif

endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer
// Description : Packs P_NUM_WORDS narrow val/rdy words into one wide message,
//               lane 0 first. Optional early flush: STREAM_PACKER_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int P_BIT_WIDTH = C_DEF_BIT_WIDTH,
    parameter int P_NUM_WORDS = C_DEF_NUM_WORDS
)(
    input  wire logic      clk,
    input  wire logic      async_rst,
    stream_packer_if.slave s
);

    localparam int C_IDX_W = idx_width(P_NUM_WORDS);
    localparam int C_BUS_W = P_BIT_WIDTH * P_NUM_WORDS;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(P_NUM_WORDS - 1);

    state_t               state_q;
    logic [C_IDX_W-1:0]   idx_q;
    logic [C_BUS_W-1:0]   buf_q;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_pack_done;
    logic                   w_flush_go;
    logic                   w_go_full;
    logic [P_BIT_WIDTH-1:0] w_lane0;

    // istream_rdy combinationally follows ostream_rdy while FULL so a new group
    // can start in the same cycle the finished one drains.
    assign s.istream_rdy = (state_q == FILL) || s.ostream_rdy;
    assign s.ostream_val = (state_q == FULL);
    assign s.ostream_msg = buf_q;

    assign w_in_fire   = s.istream_val && s.istream_rdy;
    assign w_out_fire  = s.ostream_val && s.ostream_rdy;
    assign w_pack_done = (state_q == FILL) && w_in_fire && (idx_q == C_LAST_IDX);
    assign w_go_full   = w_pack_done || w_flush_go;
    assign w_lane0     = w_in_fire ? s.istream_msg : '0;

`ifdef STREAM_PACKER_FLUSH_EN
    localparam int C_CNT_W = cnt_width(P_NUM_WORDS);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(P_NUM_WORDS);

    logic [C_CNT_W-1:0] cnt_q;

    // An empty group never flushes; the word arriving alongside flush is kept.
    assign w_flush_go    = s.flush && (state_q == FILL) && ((idx_q != '0) || w_in_fire);
    assign s.ostream_cnt = cnt_q;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            cnt_q <= '0;
        end else if (w_pack_done) begin
            cnt_q <= C_FULL_CNT;
        end else if (w_flush_go) begin
            cnt_q <= {1'b0, idx_q} + C_CNT_W'(w_in_fire);
        end
    end
`else
    assign w_flush_go = 1'b0;
`endif

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (w_in_fire) begin
                        buf_q[idx_q*P_BIT_WIDTH +: P_BIT_WIDTH] <= s.istream_msg;
                    end
                    if (w_go_full) begin
                        state_q <= FULL;
                        idx_q   <= '0;
                    end else if (w_in_fire) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FULL: begin
                    // Draining clears stale lanes so a flushed short group reads zeros.
                    if (w_out_fire) begin
                        state_q <= FILL;
                        buf_q   <= C_BUS_W'(w_lane0);
                        idx_q   <= w_in_fire ? C_IDX_W'(1) : '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packer
// Description : Scoreboard testbench for stream_packer (8-bit x 4 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packer;
    import stream_packer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stream_packer_if #(.P_BIT_WIDTH(8), .P_NUM_WORDS(4)) bus ();

    stream_packer #(.P_BIT_WIDTH(8), .P_NUM_WORDS(4)) dut (
        .clk       (clk),
        .async_rst (rst),
        .s         (bus.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    // Scoreboard entries: [39:32] word count, [31:0] packed message.
    logic [39:0] exp_q[$];
    logic [31:0] m_acc;
    int          m_lanes;
    logic        m_full;

    logic        s_in_fire, s_out_fire, s_exp_ok, s_rdy, s_rdy_exp;
    logic [31:0] s_out_msg;
    logic [7:0]  s_out_cnt;
    logic [39:0] s_exp;

    task automatic model_clear();
        exp_q.delete();
        m_acc   = '0;
        m_lanes = 0;
        m_full  = 1'b0;
    endtask

    // Drive one cycle at the falling edge, sample after settling, update the model.
    task automatic step(input logic v, input logic [7:0] m, input logic r, input logic f);
        logic fl;
        @(negedge clk);
        bus.istream_val = v;
        bus.istream_msg = m;
        bus.ostream_rdy = r;
`ifdef STREAM_PACKER_FLUSH_EN
        bus.flush = f;
`endif
        #1;
        s_rdy      = bus.istream_rdy;
        s_rdy_exp  = !m_full || r;
        s_in_fire  = v && bus.istream_rdy;
        s_out_fire = bus.ostream_val && r;
        s_out_msg  = bus.ostream_msg;
`ifdef STREAM_PACKER_FLUSH_EN
        s_out_cnt  = 8'(bus.ostream_cnt);
`else
        s_out_cnt  = 8'd4;
`endif
        fl = f && !m_full;
`ifndef STREAM_PACKER_FLUSH_EN
        fl = 1'b0;
`endif
        s_exp_ok = 1'b0;
        s_exp    = '0;
        if (s_out_fire) begin
            m_full = 1'b0;
            if (exp_q.size() > 0) begin
                s_exp    = exp_q.pop_front();
                s_exp_ok = 1'b1;
            end
        end
        if (s_in_fire) begin
            m_acc[m_lanes*8 +: 8] = m;
            m_lanes++;
        end
        if (m_lanes == 4 || (fl && m_lanes > 0)) begin
            exp_q.push_back({8'(m_lanes), m_acc});
            m_acc   = '0;
            m_lanes = 0;
            m_full  = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (bus.ostream_val !== 1'b0 || bus.ostream_msg !== 32'h0 || bus.istream_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: val=%b msg=%h rdy=%b, want val=0 msg=0 rdy=1",
                     bus.ostream_val, bus.ostream_msg, bus.istream_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'((i + 1) * 8'h11), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ostream_val !== 1'b1 || bus.ostream_msg !== 32'h44332211) begin
            n_err++;
            $display("FAIL full_before_reset: val=%b msg=%h, want val=1 msg=44332211",
                     bus.ostream_val, bus.ostream_msg);
        end
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.ostream_val !== 1'b0 || bus.ostream_msg !== 32'h0 || bus.istream_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async: val=%b msg=%h rdy=%b, want val=0 msg=0 rdy=1",
                     bus.ostream_val, bus.ostream_msg, bus.istream_rdy);
        end
        model_clear();
    endtask

    task automatic test_pack();
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 8; i++) begin
            step(i < 4, (i < 4) ? words[i] : 8'h00, 1'b1, 1'b0);
            if (i == 4) begin
                n_cmp++;
                if (s_out_fire !== 1'b1) begin
                    n_err++;
                    $display("FAIL pack_latency: out_fire=%b, want 1", s_out_fire);
                end
            end
            if (s_out_fire) begin
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== s_exp[31:0] || s_out_cnt !== s_exp[39:32]) begin
                    n_err++;
                    $display("FAIL pack_msg: got %h cnt %0d, want %h cnt %0d (exp_valid=%b)",
                             s_out_msg, s_out_cnt, s_exp[31:0], s_exp[39:32], s_exp_ok);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pack_drain: %0d outputs missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) step(1'b1, 8'((i + 1) * 8'h11), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0);
            n_cmp++;
            if (s_out_msg !== 32'h44332211 || s_rdy !== 1'b0 || s_rdy !== s_rdy_exp) begin
                n_err++;
                $display("FAIL bp_hold: msg=%h rdy=%b, want msg=44332211 rdy=0", s_out_msg, s_rdy);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 8'(8'h55 + i * 8'h11), 1'b1, 1'b0);
            if (i == 0) begin
                n_cmp++;
                if (s_in_fire !== 1'b1 || s_out_fire !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_release: in_fire=%b out_fire=%b, want 1 1", s_in_fire, s_out_fire);
                end
            end
            if (s_out_fire) begin
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== s_exp[31:0] || s_out_cnt !== s_exp[39:32]) begin
                    n_err++;
                    $display("FAIL bp_msg: got %h cnt %0d, want %h cnt %0d (exp_valid=%b)",
                             s_out_msg, s_out_cnt, s_exp[31:0], s_exp[39:32], s_exp_ok);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: %0d outputs missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_throughput();
        int outs = 0;
        for (int i = 0; i < 16; i++) begin
            step(i < 12, 8'(8'h30 + i), 1'b1, 1'b0);
            if (i < 12) begin
                n_cmp++;
                if (s_rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL tput_stall: cycle %0d rdy=%b, want 1", i, s_rdy);
                end
            end
            if (s_out_fire) begin
                outs++;
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== s_exp[31:0] || s_out_cnt !== s_exp[39:32]) begin
                    n_err++;
                    $display("FAIL tput_msg: got %h cnt %0d, want %h cnt %0d (exp_valid=%b)",
                             s_out_msg, s_out_cnt, s_exp[31:0], s_exp[39:32], s_exp_ok);
                end
            end
        end
        n_cmp++;
        if (outs != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL tput_count: got %0d outputs (%0d pending), want 3", outs, exp_q.size());
        end
    endtask

    task automatic test_gaps();
        int outs = 0;
        for (int i = 0; i < 20; i++) begin
            step((i % 2 == 0) && (i < 16), 8'(8'hC0 + i / 2), (i % 3) != 1, 1'b0);
            if (s_out_fire) begin
                outs++;
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== s_exp[31:0] || s_out_cnt !== s_exp[39:32]) begin
                    n_err++;
                    $display("FAIL gaps_msg: got %h cnt %0d, want %h cnt %0d (exp_valid=%b)",
                             s_out_msg, s_out_cnt, s_exp[31:0], s_exp[39:32], s_exp_ok);
                end
            end
        end
        n_cmp++;
        if (outs != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL gaps_count: got %0d outputs (%0d pending), want 2", outs, exp_q.size());
        end
    endtask

    task automatic test_reset_midpack();
        step(1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b1, 8'h98, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_clear();
        for (int i = 0; i < 7; i++) begin
            step(i < 4, 8'(8'hA0 + i), 1'b1, 1'b0);
            if (s_out_fire) begin
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== 32'hA3A2A1A0 || s_out_msg !== s_exp[31:0]) begin
                    n_err++;
                    $display("FAIL midrst_msg: got %h, want a3a2a1a0 (exp_valid=%b)", s_out_msg, s_exp_ok);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midrst_drain: %0d outputs missing, want 0", exp_q.size());
        end
    endtask

`ifdef STREAM_PACKER_FLUSH_EN
    task automatic test_flush();
        // v, msg, ordy, flush per cycle: short flush, idle flush, flush with a
        // word at idx 0, then a full group held while flush is asserted.
        logic [10:0] stim [20] = '{
            {1'b1, 8'h01, 1'b1, 1'b0}, {1'b1, 8'h02, 1'b1, 1'b0}, {1'b0, 8'h00, 1'b1, 1'b1},
            {1'b0, 8'h00, 1'b1, 1'b0}, {1'b0, 8'h00, 1'b1, 1'b1}, {1'b0, 8'h00, 1'b1, 1'b1},
            {1'b0, 8'h00, 1'b1, 1'b0}, {1'b1, 8'h05, 1'b1, 1'b1}, {1'b0, 8'h00, 1'b1, 1'b0},
            {1'b0, 8'h00, 1'b1, 1'b0}, {1'b1, 8'h61, 1'b0, 1'b0}, {1'b1, 8'h62, 1'b0, 1'b0},
            {1'b1, 8'h63, 1'b0, 1'b0}, {1'b1, 8'h64, 1'b0, 1'b0}, {1'b0, 8'h00, 1'b0, 1'b1},
            {1'b0, 8'h00, 1'b0, 1'b1}, {1'b0, 8'h00, 1'b1, 1'b1}, {1'b0, 8'h00, 1'b1, 1'b0},
            {1'b0, 8'h00, 1'b1, 1'b0}, {1'b0, 8'h00, 1'b1, 1'b0}
        };
        int outs = 0;
        for (int i = 0; i < 20; i++) begin
            step(stim[i][10], stim[i][9:2], stim[i][1], stim[i][0]);
            if (s_out_fire) begin
                outs++;
                n_cmp++;
                if (!s_exp_ok || s_out_msg !== s_exp[31:0] || s_out_cnt !== s_exp[39:32]) begin
                    n_err++;
                    $display("FAIL flush_msg: got %h cnt %0d, want %h cnt %0d (exp_valid=%b)",
                             s_out_msg, s_out_cnt, s_exp[31:0], s_exp[39:32], s_exp_ok);
                end
                if (outs == 1) begin
                    n_cmp++;
                    if (s_out_msg !== 32'h00000201 || s_out_cnt !== 8'd2) begin
                        n_err++;
                        $display("FAIL flush_short: got %h cnt %0d, want 00000201 cnt 2",
                                 s_out_msg, s_out_cnt);
                    end
                end
            end
        end
        n_cmp++;
        if (outs != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_count: got %0d outputs (%0d pending), want 3", outs, exp_q.size());
        end
    endtask
`endif

    initial begin
        bus.istream_val = 1'b0;
        bus.istream_msg = 8'h00;
        bus.ostream_rdy = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
        bus.flush = 1'b0;
`endif
        model_clear();
        #1 rst = 1'b1;
        test_reset();
        test_pack();
        test_backpressure();
        test_throughput();
        test_gaps();
        test_reset_midpack();
`ifdef STREAM_PACKER_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
